lisnoc_packet_injector: RTL and testbench

- Local-port injection stage that sits directly upstream of a router input port.
- Turns a command (destination, priority, virtual channel, length) plus a stream of data words into a LISNoC packet: one header flit, then payload flits.
- The flit is held in a single output register and presented on one-hot per-VC valid/ready, matching the router link format.
- A packet is never interleaved with another on the output.

---
 rtl/lisnoc_def.sv | 26 ++
 rtl/lisnoc_injector_outreg.sv | 44 ++++
 rtl/lisnoc_packet_injector.sv | 137 +++++++++++++
 tb/tb_lisnoc_packet_injector.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lisnoc_def.sv
// rtl/lisnoc_def.sv - shared LISNoC flit type codes, header field placement and injector state encoding
// Purpose: definitions shared by the packet injector and its output register.
// Ports: none (package).
package lisnoc_def;

  localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
  localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } inj_state_e;

  // Destination is MSB-aligned in the header data word.
  function automatic int ph_dest_lsb(input int data_width, input int dest_width);
    return data_width - dest_width;
  endfunction

  // Priority sits directly below the destination, i.e. PH_DEST_WIDTH down from the top.
  function automatic int ph_prio_lsb(input int data_width, input int dest_width, input int prio_width);
    return data_width - dest_width - prio_width;
  endfunction

endpackage

// File: rtl/lisnoc_injector_outreg.sv
// rtl/lisnoc_injector_outreg.sv - single-entry flit holding register with per-VC valid/ready
// Purpose: holds one flit toward the router and reports when a new flit may be loaded.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   load              - capture load_flit/load_valid this cycle (only asserted when free)
//   load_flit         - flit to capture
//   load_valid        - one-hot VC valid to present with the flit
//   flit, valid       - registered flit and one-hot valid toward the router
//   ready             - per-VC ready from the router
//   free              - register empty or draining this cycle
module lisnoc_injector_outreg #(
  parameter int FLIT_WIDTH = 34,
  parameter int VCHANNELS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FLIT_WIDTH-1:0] load_flit,
  input  logic [VCHANNELS-1:0]  load_valid,
  output logic [FLIT_WIDTH-1:0] flit,
  output logic [VCHANNELS-1:0]  valid,
  input  logic [VCHANNELS-1:0]  ready,
  output logic                  free
);

  logic drain;

  // valid is one-hot on the held VC, so masking with it ignores ready on other VCs.
  assign drain = |(valid & ready);
  assign free  = !(|valid) || drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit  <= '0;
      valid <= '0;
    end else if (load) begin
      flit  <= load_flit;
      valid <= load_valid;
    end else if (drain) begin
      valid <= '0;
    end
  end

endmodule

// File: rtl/lisnoc_packet_injector.sv
// rtl/lisnoc_packet_injector.sv - builds LISNoC packets (header + payload flits) from command and data streams
// Purpose: local-port injection stage directly upstream of a router input port.
// Ports:
//   clk, rst                                  - clock, asynchronous active-high reset
//   cmd_dest/prio/vc/len, cmd_valid/cmd_ready - packet command
//   in_data, in_valid/in_ready                - payload words
//   out_flit, out_valid/out_ready             - {type,data} flit with one-hot per-VC handshake
module lisnoc_packet_injector
  import lisnoc_def::*;
#(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int PH_DEST_WIDTH   = 5,
  parameter int PH_PRIO_WIDTH   = 4,
  parameter int VCHANNELS       = 1,
  parameter int LEN_WIDTH       = 4,
  localparam int FLIT_WIDTH     = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
  localparam int VC_WIDTH       = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PH_DEST_WIDTH-1:0]   cmd_dest,
  input  logic [PH_PRIO_WIDTH-1:0]   cmd_prio,
  input  logic [VC_WIDTH-1:0]        cmd_vc,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [FLIT_DATA_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FLIT_WIDTH-1:0]      out_flit,
  output logic [VCHANNELS-1:0]       out_valid,
  input  logic [VCHANNELS-1:0]       out_ready
);

  localparam int DEST_LSB = ph_dest_lsb(FLIT_DATA_WIDTH, PH_DEST_WIDTH);
  localparam int PRIO_LSB = ph_prio_lsb(FLIT_DATA_WIDTH, PH_DEST_WIDTH, PH_PRIO_WIDTH);
  localparam logic [VC_WIDTH:0] NUM_VC = VCHANNELS[VC_WIDTH:0];

  inj_state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]       remaining_q, remaining_d;
  logic [VC_WIDTH-1:0]        vc_q, vc_d;
  logic [VC_WIDTH-1:0]        cmd_vc_eff;
  logic [VC_WIDTH-1:0]        sel_vc;
  logic [VCHANNELS-1:0]       sel_onehot;
  logic [FLIT_DATA_WIDTH-1:0] header;
  logic                       free;
  logic                       load;
  logic [FLIT_WIDTH-1:0]      load_flit;

  // Out-of-range VCs fall back to VC 0 so the valid vector stays one-hot.
  assign cmd_vc_eff = ({1'b0, cmd_vc} < NUM_VC) ? cmd_vc : '0;
  assign sel_vc     = (state_q == ST_IDLE) ? cmd_vc_eff : vc_q;

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < VCHANNELS; i++) begin
      sel_onehot[i] = (sel_vc == i[VC_WIDTH-1:0]);
    end
  end

  always_comb begin
    header = '0;
    header[DEST_LSB +: PH_DEST_WIDTH] = cmd_dest;
    header[PRIO_LSB +: PH_PRIO_WIDTH] = cmd_prio;
    header[LEN_WIDTH-1:0]             = cmd_len;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    vc_d        = vc_q;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    load        = 1'b0;
    load_flit   = '0;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst so no handshake is offered while reset is held.
        cmd_ready = free && !rst;
        if (cmd_valid && cmd_ready) begin
          load        = 1'b1;
          vc_d        = cmd_vc_eff;
          remaining_d = cmd_len;
          if (cmd_len != '0) begin
            load_flit = {FLIT_TYPE_WIDTH'(FLIT_TYPE_HEADER), header};
            state_d   = ST_PAYLOAD;
          end else begin
            load_flit = {FLIT_TYPE_WIDTH'(FLIT_TYPE_SINGLE), header};
          end
        end
      end
      ST_PAYLOAD: begin
        in_ready = free && !rst;
        if (in_valid && in_ready) begin
          load        = 1'b1;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            load_flit = {FLIT_TYPE_WIDTH'(FLIT_TYPE_LAST), in_data};
            state_d   = ST_IDLE;
          end else begin
            load_flit = {FLIT_TYPE_WIDTH'(FLIT_TYPE_PAYLOAD), in_data};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      vc_q        <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      vc_q        <= vc_d;
    end
  end

  lisnoc_injector_outreg #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .VCHANNELS  (VCHANNELS)
  ) u_outreg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_flit  (load_flit),
    .load_valid (sel_onehot),
    .flit       (out_flit),
    .valid      (out_valid),
    .ready      (out_ready),
    .free       (free)
  );

endmodule

// File: tb/tb_lisnoc_packet_injector.sv
// tb/tb_lisnoc_packet_injector.sv - self-checking bench for lisnoc_packet_injector
module tb_lisnoc_packet_injector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT0: default single-VC configuration
  logic [4:0]  cmd_dest;
  logic [3:0]  cmd_prio;
  logic [0:0]  cmd_vc;
  logic [3:0]  cmd_len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] out_flit;
  logic [0:0]  out_valid;
  logic [0:0]  out_ready;

  lisnoc_packet_injector dut0 (
    .clk(clk), .rst(rst),
    .cmd_dest(cmd_dest), .cmd_prio(cmd_prio), .cmd_vc(cmd_vc), .cmd_len(cmd_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready)
  );

  // DUT1: two virtual channels
  logic [4:0]  c1_dest;
  logic [3:0]  c1_prio;
  logic [0:0]  c1_vc;
  logic [3:0]  c1_len;
  logic        c1_valid;
  logic        c1_ready;
  logic [31:0] i1_data;
  logic        i1_valid;
  logic        i1_ready;
  logic [33:0] o1_flit;
  logic [1:0]  o1_valid;
  logic [1:0]  o1_ready;

  lisnoc_packet_injector #(.VCHANNELS(2)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_dest(c1_dest), .cmd_prio(c1_prio), .cmd_vc(c1_vc), .cmd_len(c1_len),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .in_data(i1_data), .in_valid(i1_valid), .in_ready(i1_ready),
    .out_flit(o1_flit), .out_valid(o1_valid), .out_ready(o1_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Header flit as laid out on the link: {type, dest[31:27], prio[26:23], zeros, len[3:0]}
  function automatic logic [33:0] hdr(input logic [1:0] t, input logic [4:0] d,
                                      input logic [3:0] p, input logic [3:0] l);
    return {t, d, p, 19'b0, l};
  endfunction

  function automatic logic [33:0] dat(input logic [1:0] t, input logic [31:0] w);
    return {t, w};
  endfunction

  typedef struct {
    logic        cv;
    logic [4:0]  dest;
    logic [3:0]  prio;
    logic [0:0]  vc;
    logic [3:0]  len;
    logic        iv;
    logic [31:0] data;
    logic        ordy;
    logic        ecr;
    logic        eir;
    logic        ev;
    logic [33:0] ef;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // cv dest prio vc len | iv data | ordy | exp cmd_ready in_ready (pre-edge) | exp valid flit (post-edge)
    tbl[0]  = '{1, 5'd5,  4'd3,  0, 4'd0, 0, 32'h0,         1, 1, 0, 1, hdr(2'b11, 5'd5, 4'd3, 4'd0)};
    tbl[1]  = '{0, 5'd0,  4'd0,  0, 4'd0, 0, 32'h0,         1, 1, 0, 0, hdr(2'b11, 5'd5, 4'd3, 4'd0)};
    tbl[2]  = '{1, 5'd9,  4'd10, 1, 4'd3, 0, 32'h0,         1, 1, 0, 1, hdr(2'b01, 5'd9, 4'd10, 4'd3)};
    tbl[3]  = '{0, 5'd0,  4'd0,  0, 4'd0, 1, 32'hA1A1_0001, 1, 0, 1, 1, dat(2'b00, 32'hA1A1_0001)};
    tbl[4]  = '{0, 5'd0,  4'd0,  0, 4'd0, 1, 32'hA2A2_0002, 1, 0, 1, 1, dat(2'b00, 32'hA2A2_0002)};
    tbl[5]  = '{0, 5'd0,  4'd0,  0, 4'd0, 1, 32'hA3A3_0003, 1, 0, 1, 1, dat(2'b10, 32'hA3A3_0003)};
    tbl[6]  = '{0, 5'd0,  4'd0,  0, 4'd0, 1, 32'hDEAD_BEEF, 1, 1, 0, 0, dat(2'b10, 32'hA3A3_0003)};
    tbl[7]  = '{1, 5'd1,  4'd2,  0, 4'd2, 0, 32'h0,         0, 1, 0, 1, hdr(2'b01, 5'd1, 4'd2, 4'd2)};
    tbl[8]  = '{0, 5'd0,  4'd0,  0, 4'd0, 1, 32'hB1B1_0001, 0, 0, 0, 1, hdr(2'b01, 5'd1, 4'd2, 4'd2)};
    tbl[9]  = '{0, 5'd0,  4'd0,  0, 4'd0, 1, 32'hB1B1_0001, 0, 0, 0, 1, hdr(2'b01, 5'd1, 4'd2, 4'd2)};
    tbl[10] = '{0, 5'd0,  4'd0,  0, 4'd0, 1, 32'hB1B1_0001, 0, 0, 0, 1, hdr(2'b01, 5'd1, 4'd2, 4'd2)};
    tbl[11] = '{0, 5'd0,  4'd0,  0, 4'd0, 1, 32'hB1B1_0001, 0, 0, 0, 1, hdr(2'b01, 5'd1, 4'd2, 4'd2)};
    tbl[12] = '{0, 5'd0,  4'd0,  0, 4'd0, 1, 32'hB1B1_0001, 1, 0, 1, 1, dat(2'b00, 32'hB1B1_0001)};
    tbl[13] = '{1, 5'd31, 4'd15, 0, 4'd0, 1, 32'hB2B2_0002, 1, 0, 1, 1, dat(2'b10, 32'hB2B2_0002)};
    tbl[14] = '{1, 5'd31, 4'd15, 0, 4'd0, 1, 32'h5555_5555, 1, 1, 0, 1, hdr(2'b11, 5'd31, 4'd15, 4'd0)};
    tbl[15] = '{0, 5'd0,  4'd0,  0, 4'd0, 0, 32'h0,         1, 1, 0, 0, hdr(2'b11, 5'd31, 4'd15, 4'd0)};
    tbl[16] = '{1, 5'd2,  4'd1,  0, 4'd15, 0, 32'h0,        0, 1, 0, 1, hdr(2'b01, 5'd2, 4'd1, 4'd15)};
  end

  task automatic idle_inputs();
    cmd_valid = 0; cmd_dest = '0; cmd_prio = '0; cmd_vc = '0; cmd_len = '0;
    in_valid = 0; in_data = '0; out_ready = 1'b1;
    c1_valid = 0; c1_dest = '0; c1_prio = '0; c1_vc = '0; c1_len = '0;
    i1_valid = 0; i1_data = '0; o1_ready = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_out_flit", 64'(out_flit), 64'h0);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Table-driven: single flit, full-throughput packet, backpressure, hold-off, max length header
    for (int i = 0; i < 17; i++) begin
      cmd_valid = tbl[i].cv; cmd_dest = tbl[i].dest; cmd_prio = tbl[i].prio;
      cmd_vc = tbl[i].vc; cmd_len = tbl[i].len;
      in_valid = tbl[i].iv; in_data = tbl[i].data; out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_cmd_ready", i), 64'(cmd_ready), 64'(tbl[i].ecr));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].eir));
      step();
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_out_flit", i), 64'(out_flit), 64'(tbl[i].ef));
    end
    idle_inputs();

    // Reset mid-packet: header of a 3-word packet plus one word, then async reset
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_clears_len15_pkt", 64'(out_valid), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    cmd_valid = 1; cmd_dest = 5'd6; cmd_prio = 4'd4; cmd_len = 4'd3;
    step();
    cmd_valid = 0;
    in_valid = 1; in_data = 32'hC0C0_0001;
    step();
    chk("midpkt_word1", 64'(out_flit), 64'(dat(2'b00, 32'hC0C0_0001)));
    #2;
    rst = 1'b1;
    #1;
    chk("midpkt_rst_out_valid", 64'(out_valid), 64'h0);
    chk("midpkt_rst_out_flit", 64'(out_flit), 64'h0);
    chk("midpkt_rst_in_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1; in_data = 32'hC0C0_0002;
    cmd_valid = 1; cmd_dest = 5'd4; cmd_prio = 4'd8; cmd_len = 4'd0;
    #1;
    chk("postrst_idle_cmd_ready", 64'(cmd_ready), 64'h1);
    chk("postrst_idle_in_ready", 64'(in_ready), 64'h0);
    step();
    chk("postrst_fresh_single", 64'(out_flit), 64'(hdr(2'b11, 5'd4, 4'd8, 4'd0)));
    chk("postrst_valid", 64'(out_valid), 64'h1);
    idle_inputs();
    step();
    chk("postrst_drained", 64'(out_valid), 64'h0);

    // VC selection on the two-VC instance
    c1_valid = 1; c1_vc = 1'b1; c1_dest = 5'd3; c1_prio = 4'd2; c1_len = 4'd1;
    o1_ready = 2'b01;
    step();
    c1_valid = 0;
    chk("vc1_header_valid", 64'(o1_valid), 64'h2);
    chk("vc1_header_flit", 64'(o1_flit), 64'(hdr(2'b01, 5'd3, 4'd2, 4'd1)));
    i1_valid = 1; i1_data = 32'hD1D1_0001;
    @(negedge clk);
    chk("vc1_wrong_ready_in_ready", 64'(i1_ready), 64'h0);
    step();
    chk("vc1_wrong_ready_held", 64'(o1_valid), 64'h2);
    chk("vc1_wrong_ready_flit", 64'(o1_flit), 64'(hdr(2'b01, 5'd3, 4'd2, 4'd1)));
    o1_ready = 2'b10;
    @(negedge clk);
    chk("vc1_right_ready_in_ready", 64'(i1_ready), 64'h1);
    step();
    i1_valid = 0;
    chk("vc1_last_flit", 64'(o1_flit), 64'(dat(2'b10, 32'hD1D1_0001)));
    chk("vc1_last_valid", 64'(o1_valid), 64'h2);
    step();
    chk("vc1_drained", 64'(o1_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
